// File: rtl/adder_chk_pkg.sv
// Shared types for the adder response checker.
// Entry layout, FSM states and counter width.
package adder_chk_pkg;

  localparam int MAX_W = 64;
  localparam int WID_W = $clog2(MAX_W) + 1;
  localparam int CNT_W = 32;

  typedef struct packed {
    logic [MAX_W-1:0] sum;
    logic             cout;
    logic [WID_W-1:0] width;
    logic [CNT_W-1:0] index;
  } chk_entry_t;

  typedef enum logic {
    ACTIVE = 1'b0,
    FAULT  = 1'b1
  } chk_state_e;

endpackage

// File: rtl/chk_fifo.sv
// Synchronous FIFO of expected-result entries.
// Registered full/empty/count; push and pop may coincide.
module chk_fifo
  import adder_chk_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  chk_entry_t               din,
  input  logic                     pop,
  output chk_entry_t               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  chk_entry_t      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;
  logic [AW:0]     count_n;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_comb begin
    count_n = count;
    if (do_push && !do_pop) count_n = count + 1'b1;
    if (!do_push && do_pop) count_n = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_n;
      full  <= (count_n == (AW+1)'(DEPTH));
      empty <= (count_n == '0);
    end
  end

endmodule

// File: rtl/adder_checker.sv
// In-order response checker for the adderN block.
// Queues expected sum/carry per vector and scores DUT replies.
module adder_checker
  import adder_chk_pkg::*;
#(
  parameter int MAX_WIDTH = 64,
  parameter int DEPTH     = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         stim_valid,
  output logic                         stim_ready,
  input  logic [MAX_WIDTH-1:0]         stim_a,
  input  logic [MAX_WIDTH-1:0]         stim_b,
  input  logic                         stim_cin,
  input  logic [$clog2(MAX_WIDTH):0]   stim_width,
  input  logic                         rsp_valid,
  input  logic [MAX_WIDTH-1:0]         rsp_sum,
  input  logic                         rsp_cout,
  output logic [CNT_W-1:0]             pass_cnt,
  output logic [CNT_W-1:0]             fail_cnt,
  output logic                         err_flag,
  output logic [CNT_W-1:0]             err_index,
  output logic [MAX_WIDTH-1:0]         err_exp_sum,
  output logic [MAX_WIDTH-1:0]         err_got_sum,
  output logic                         err_exp_cout,
  output logic                         err_got_cout,
  output logic                         proto_err,
  output logic [$clog2(DEPTH):0]       pending
);

  chk_state_e          state;
  chk_state_e          state_n;
  logic                flush;
  logic                push;
  logic                pop;
  logic                proto_set;
  logic                q_full;
  logic                q_empty;
  chk_entry_t          q_din;
  chk_entry_t          q_head;
  logic [CNT_W-1:0]    idx;
  logic [WID_W-1:0]    eff_w;
  logic [MAX_WIDTH-1:0] in_mask;
  logic [MAX_WIDTH-1:0] hd_mask;
  logic [MAX_WIDTH:0]  full_sum;
  logic [MAX_WIDTH-1:0] got_sum;
  logic                match;

  function automatic logic [MAX_WIDTH-1:0] mask_of(
    input logic [WID_W-1:0] w
  );
    return ~({MAX_WIDTH{1'b1}} << w);
  endfunction

  assign flush = rst || clear;

  assign eff_w = (stim_width == '0 ||
                  int'(stim_width) > MAX_WIDTH)
               ? WID_W'(MAX_WIDTH)
               : WID_W'(stim_width);

  assign in_mask  = mask_of(eff_w);
  assign full_sum = {1'b0, stim_a & in_mask}
                  + {1'b0, stim_b & in_mask}
                  + (MAX_WIDTH+1)'(stim_cin);

  always_comb begin
    q_din       = '0;
    q_din.sum   = MAX_W'(full_sum[MAX_WIDTH-1:0] & in_mask);
    q_din.cout  = full_sum[eff_w];
    q_din.width = eff_w;
    q_din.index = idx;
  end

  assign hd_mask = mask_of(q_head.width);
  assign got_sum = rsp_sum & hd_mask;
  assign match   = (got_sum == q_head.sum[MAX_WIDTH-1:0])
                && (rsp_cout == q_head.cout);

  assign stim_ready = !q_full && (state == ACTIVE);

  always_comb begin
    state_n   = state;
    push      = 1'b0;
    pop       = 1'b0;
    proto_set = 1'b0;
    unique case (state)
      ACTIVE: begin
        if (rsp_valid && q_empty) begin
          state_n   = FAULT;
          proto_set = 1'b1;
        end else begin
          push = stim_valid && stim_ready;
          pop  = rsp_valid;
        end
      end
      FAULT: begin
        state_n = FAULT;
      end
      default: state_n = ACTIVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (flush) state <= ACTIVE;
    else       state <= state_n;
  end

  chk_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (flush),
    .push  (push),
    .din   (q_din),
    .pop   (pop),
    .dout  (q_head),
    .full  (q_full),
    .empty (q_empty),
    .count (pending)
  );

  always_ff @(posedge clk) begin
    if (flush) begin
      idx          <= '0;
      pass_cnt     <= '0;
      fail_cnt     <= '0;
      err_flag     <= 1'b0;
      err_index    <= '0;
      err_exp_sum  <= '0;
      err_got_sum  <= '0;
      err_exp_cout <= 1'b0;
      err_got_cout <= 1'b0;
      proto_err    <= 1'b0;
    end else begin
      if (push) idx <= idx + 1'b1;
      if (proto_set) proto_err <= 1'b1;
      if (pop && match) begin
        if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
      end
      if (pop && !match) begin
        if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
        if (!err_flag) begin
          err_flag     <= 1'b1;
          err_index    <= q_head.index;
          err_exp_sum  <= q_head.sum[MAX_WIDTH-1:0];
          err_got_sum  <= got_sum;
          err_exp_cout <= q_head.cout;
          err_got_cout <= rsp_cout;
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_checker.sv
// Randomised self-checking bench for adder_checker.
// Reference model is a plain arithmetic scoreboard queue.
module tb_adder_checker;

  logic        clk = 1'b0;
  logic        rst, clear;
  logic        stim_valid, stim_ready;
  logic [63:0] stim_a, stim_b;
  logic        stim_cin;
  logic [6:0]  stim_width;
  logic        rsp_valid;
  logic [63:0] rsp_sum;
  logic        rsp_cout;
  logic [31:0] pass_cnt, fail_cnt, err_index;
  logic        err_flag, err_exp_cout, err_got_cout, proto_err;
  logic [63:0] err_exp_sum, err_got_sum;
  logic [3:0]  pending;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    int          w;
    int          idx;
  } exp_t;

  exp_t        mq[$];
  int          mpass, mfail, midx;
  bit          merr, mfault;
  int          mei;
  logic [63:0] mes, mgs;
  logic        mec, mgc;

  adder_checker #(.MAX_WIDTH(64), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .stim_valid(stim_valid), .stim_ready(stim_ready),
    .stim_a(stim_a), .stim_b(stim_b), .stim_cin(stim_cin),
    .stim_width(stim_width),
    .rsp_valid(rsp_valid), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .err_flag(err_flag), .err_index(err_index),
    .err_exp_sum(err_exp_sum), .err_got_sum(err_got_sum),
    .err_exp_cout(err_exp_cout), .err_got_cout(err_got_cout),
    .proto_err(proto_err), .pending(pending)
  );

  always #5 clk = ~clk;

  function automatic int eff(input int w);
    return (w == 0 || w > 64) ? 64 : w;
  endfunction

  function automatic logic [63:0] wmask(input int w);
    logic [64:0] m;
    m = (65'd1 << w) - 65'd1;
    return m[63:0];
  endfunction

  task automatic model_reset();
    mq.delete();
    mpass = 0; mfail = 0; midx = 0;
    merr = 0; mfault = 0;
    mei = 0; mes = 0; mgs = 0; mec = 0; mgc = 0;
  endtask

  task automatic idle();
    stim_valid = 0; stim_a = 0; stim_b = 0;
    stim_cin = 0; stim_width = 0;
    rsp_valid = 0; rsp_sum = 0; rsp_cout = 0;
  endtask

  task automatic step(input bit sv, input logic [63:0] a,
                      input logic [63:0] b, input bit ci,
                      input int wd, input bit rv,
                      input logic [63:0] rs, input bit rc);
    exp_t e, h;
    int w, n0;
    logic [64:0] f;
    stim_valid = sv; stim_a = a; stim_b = b;
    stim_cin = ci; stim_width = 7'(wd);
    rsp_valid = rv; rsp_sum = rs; rsp_cout = rc;
    n0 = mq.size();
    if (!mfault) begin
      if (rv && n0 == 0) begin
        mfault = 1;
      end else begin
        if (rv) begin
          h = mq.pop_front();
          if (((rs & wmask(h.w)) == h.sum) && rc == h.cout) begin
            mpass++;
          end else begin
            mfail++;
            if (!merr) begin
              merr = 1; mei = h.idx; mes = h.sum;
              mgs = rs & wmask(h.w); mec = h.cout; mgc = rc;
            end
          end
        end
        if (sv && n0 < 8) begin
          w = eff(wd);
          f = {1'b0, a & wmask(w)} + {1'b0, b & wmask(w)} + 65'(ci);
          e.sum = f[63:0] & wmask(w);
          e.cout = f[w];
          e.w = w;
          e.idx = midx;
          midx++;
          mq.push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic do_clear(input bit use_rst);
    rst = use_rst; clear = !use_rst;
    @(posedge clk);
    #1;
    rst = 0; clear = 0;
    model_reset();
  endtask

  task automatic test_reset();
    idle();
    rst = 0; clear = 0;
    do_clear(1);
    checks++;
    if (pass_cnt !== 0 || fail_cnt !== 0 || err_flag !== 0 ||
        proto_err !== 0 || pending !== 0 || stim_ready !== 1 ||
        err_index !== 0 || err_exp_sum !== 0 || err_got_sum !== 0) begin
      failures++;
      $display("FAIL reset: pass=%0d fail=%0d err=%b proto=%b pend=%0d rdy=%b, required 0/0/0/0/0/1",
               pass_cnt, fail_cnt, err_flag, proto_err, pending, stim_ready);
    end
  endtask

  task automatic test_basic();
    step(1, 64'hF, 64'h1, 0, 4, 0, 0, 0);
    checks++;
    if (pending !== 1) begin
      failures++;
      $display("FAIL basic_pending: got %0d required 1", pending);
    end
    step(0, 0, 0, 0, 0, 1, 64'h0, 1);
    checks++;
    if (pass_cnt !== 1 || fail_cnt !== 0 || err_flag !== 0 ||
        pass_cnt !== mpass) begin
      failures++;
      $display("FAIL basic_w4: pass=%0d fail=%0d err=%b required 1/0/0",
               pass_cnt, fail_cnt, err_flag);
    end
  endtask

  task automatic test_mismatch();
    do_clear(0);
    step(1, 64'h05, 64'h03, 0, 8, 0, 0, 0);
    step(1, 64'h10, 64'h01, 0, 8, 1, 64'h08, 0);
    step(1, 64'hFF, 64'h01, 0, 8, 1, 64'h10, 0);
    step(0, 0, 0, 0, 0, 1, 64'h00, 1);
    checks++;
    if (pass_cnt !== 2 || fail_cnt !== 1 || err_flag !== 1) begin
      failures++;
      $display("FAIL mismatch_cnt: pass=%0d fail=%0d err=%b required 2/1/1",
               pass_cnt, fail_cnt, err_flag);
    end
    checks++;
    if (err_index !== 1 || err_exp_sum !== 64'h11 ||
        err_got_sum !== 64'h10 || err_exp_cout !== 0 ||
        err_got_cout !== 0) begin
      failures++;
      $display("FAIL mismatch_capture: idx=%0d exp=%h got=%h required 1/11/10",
               err_index, err_exp_sum, err_got_sum);
    end
  endtask

  task automatic test_upper_ignored();
    do_clear(0);
    step(1, 64'h0F, 64'h0, 0, 4, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 64'hFF, 0);
    checks++;
    if (pass_cnt !== 1 || fail_cnt !== 0) begin
      failures++;
      $display("FAIL upper_ignored: pass=%0d fail=%0d required 1/0",
               pass_cnt, fail_cnt);
    end
  endtask

  task automatic test_full();
    exp_t h;
    do_clear(0);
    for (int i = 0; i < 8; i++)
      step(1, 64'(i), 64'(i), 0, 16, 0, 0, 0);
    checks++;
    if (pending !== 8 || stim_ready !== 0) begin
      failures++;
      $display("FAIL full: pend=%0d rdy=%b required 8/0", pending, stim_ready);
    end
    step(1, 64'h1234, 64'h1, 0, 16, 0, 0, 0);
    checks++;
    if (pending !== 8) begin
      failures++;
      $display("FAIL full_drop: pend=%0d required 8", pending);
    end
    h = mq[0];
    step(0, 0, 0, 0, 0, 1, h.sum, h.cout);
    checks++;
    if (stim_ready !== 1 || pending !== 7 || pass_cnt !== 1) begin
      failures++;
      $display("FAIL full_release: rdy=%b pend=%0d pass=%0d required 1/7/1",
               stim_ready, pending, pass_cnt);
    end
  endtask

  task automatic test_proto();
    do_clear(0);
    step(0, 0, 0, 0, 0, 1, 64'h0, 0);
    checks++;
    if (proto_err !== 1 || stim_ready !== 0) begin
      failures++;
      $display("FAIL proto: proto=%b rdy=%b required 1/0", proto_err, stim_ready);
    end
    step(1, 64'h1, 64'h1, 0, 8, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 64'h2, 0);
    checks++;
    if (pass_cnt !== 0 || fail_cnt !== 0 || pending !== 0) begin
      failures++;
      $display("FAIL proto_frozen: pass=%0d fail=%0d pend=%0d required 0/0/0",
               pass_cnt, fail_cnt, pending);
    end
    do_clear(0);
    checks++;
    if (proto_err !== 0 || stim_ready !== 1 || pass_cnt !== 0 ||
        fail_cnt !== 0 || err_flag !== 0 || pending !== 0) begin
      failures++;
      $display("FAIL proto_clear: proto=%b rdy=%b pend=%0d required 0/1/0",
               proto_err, stim_ready, pending);
    end
    step(1, 64'h1, 64'h1, 0, 8, 1, 64'h2, 0);
    checks++;
    if (proto_err !== 1 || pending !== 0) begin
      failures++;
      $display("FAIL proto_same_cycle: proto=%b pend=%0d required 1/0",
               proto_err, pending);
    end
  endtask

  task automatic test_width_edge();
    do_clear(0);
    step(1, '1, '1, 1, 0, 0, 0, 0);
    step(1, '1, '1, 1, 65, 1, '1, 1);
    step(0, 0, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 1);
    checks++;
    if (pass_cnt !== 1 || fail_cnt !== 1 || err_index !== 1 ||
        err_exp_sum !== '1 || err_exp_cout !== 1) begin
      failures++;
      $display("FAIL width_edge: pass=%0d fail=%0d idx=%0d exp=%h c=%b required 1/1/1/all-ones/1",
               pass_cnt, fail_cnt, err_index, err_exp_sum, err_exp_cout);
    end
  endtask

  task automatic test_back_to_back();
    exp_t h;
    bit sv, rv, ci;
    logic [63:0] a, b, rs;
    bit rc;
    int wd;
    do_clear(0);
    for (int i = 0; i < 400; i++) begin
      sv = ($urandom_range(0, 3) != 0);
      rv = (mq.size() > 0) && ($urandom_range(0, 2) != 0);
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      ci = $urandom_range(0, 1);
      wd = $urandom_range(0, 70);
      rs = {$urandom, $urandom};
      rc = $urandom_range(0, 1);
      if (rv) begin
        h = mq[0];
        rs = (rs & ~wmask(h.w)) | h.sum;
        rc = h.cout;
        if ($urandom_range(0, 5) == 0) begin
          if ($urandom_range(0, 1) == 0) rc = ~rc;
          else rs[$urandom_range(0, h.w - 1)] ^= 1'b1;
        end
      end
      checks++;
      if (stim_ready !== (mq.size() < 8)) begin
        failures++;
        $display("FAIL rand_ready[%0d]: got %b required %b",
                 i, stim_ready, mq.size() < 8);
      end
      step(sv, a, b, ci, wd, rv, rs, rc);
      checks++;
      if (pass_cnt !== mpass || fail_cnt !== mfail ||
          pending !== mq.size()) begin
        failures++;
        $display("FAIL rand_cnt[%0d]: pass=%0d fail=%0d pend=%0d required %0d/%0d/%0d",
                 i, pass_cnt, fail_cnt, pending, mpass, mfail, mq.size());
      end
    end
    checks++;
    if (err_flag !== merr || proto_err !== 0 ||
        (merr && (err_index !== mei || err_exp_sum !== mes ||
                  err_got_sum !== mgs || err_exp_cout !== mec ||
                  err_got_cout !== mgc))) begin
      failures++;
      $display("FAIL rand_capture: err=%b idx=%0d exp=%h got=%h required %b/%0d/%h/%h",
               err_flag, err_index, err_exp_sum, err_got_sum,
               merr, mei, mes, mgs);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mismatch();
    test_upper_ignored();
    test_full();
    test_proto();
    test_width_edge();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_checker.md
# adder_checker

Self-checking response end of the adder verification flow: accepts the stimulus vectors that are driven into `adderN`, computes the expected sum/carry per vector at the vector's active bit width, queues them, and compares each returning DUT response in order. It keeps pass/fail counters and captures the first mismatch, so RTL simulation and FPGA soak runs report results without file post-processing. It sits beside the `adderN` instance, tapping the stimulus bus and the DUT outputs.

## Interface
- `MAX_WIDTH`, 64: maximum adder width; all data ports are this wide.
- `DEPTH`, 8: expected-result queue depth, power of two, ≥2.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `clear`  in  1: synchronous soft clear, same effect as `rst`; `rst` has priority.
- `stim_valid`  in  1: stimulus vector present.
- `stim_ready`  out  1: checker can accept a vector.
- `stim_a`, `stim_b`  in  MAX_WIDTH: operands; only the low `stim_width` bits are significant.
- `stim_cin`  in  1: carry-in.
- `stim_width`  in  $clog2(MAX_WIDTH)+1: active width; 0 or >MAX_WIDTH is treated as MAX_WIDTH.
- `rsp_valid`  in  1: DUT response present, one per accepted vector, in order.
- `rsp_sum`  in  MAX_WIDTH, `rsp_cout`  in  1: DUT result.
- `pass_cnt`, `fail_cnt`  out  32: saturating counters.
- `err_flag`  out  1: sticky; first mismatch captured.
- `err_index`  out  32: vector number (0-based, acceptance order) of first mismatch.
- `err_exp_sum`, `err_got_sum`  out  MAX_WIDTH; `err_exp_cout`, `err_got_cout`  out  1.
- `proto_err`  out  1: sticky; response arrived with empty queue.
- `pending`  out  $clog2(DEPTH)+1: queue occupancy.

## Operation
- Reset values: all counters, `err_*`, `proto_err`, `pending` = 0; `stim_ready` = 1; state ACTIVE.
- States: ACTIVE, FAULT. ACTIVE→FAULT on `rsp_valid` with `pending`==0 (sets `proto_err`). FAULT exits only via `rst`/`clear`.
- Accept: `stim_valid && stim_ready`. `stim_ready` = (`pending` < DEPTH) && state==ACTIVE; depends only on registered state.
- On accept: w = effective width; full = a[w-1:0] + b[w-1:0] + cin at w+1 bits; expected sum = full[w-1:0] zero-extended, expected cout = full[w]; entry {sum, cout, w, index} pushed. Index counter increments per accept, wraps at 2^32.
- On `rsp_valid` in ACTIVE with `pending`>0: pop head; compare `rsp_sum[w-1:0]` and `rsp_cout` against the entry; bits above w are ignored. Match → `pass_cnt`+1, else `fail_cnt`+1 and, if `err_flag`==0, capture index, expected and got (got sum masked to w bits), set `err_flag`.
- Counters saturate at 2^32−1; no wrap.
- Push and pop in the same cycle with `pending`>0: both occur, `pending` unchanged. Push with `pending`==0 plus `rsp_valid` same cycle: protocol error (response must trail its stimulus by ≥1 cycle); push is dropped on FAULT entry.
- `rsp_valid` in FAULT: ignored, counters frozen.

## Timing
- Expected entry visible at queue head the cycle after acceptance.
- Comparison is registered: counters/`err_*` update on the edge that consumes the response; visible next cycle.
- `pending` updates on the same edge as push/pop.
- `rst`/`clear` mid-run: queue flushed, in-flight responses afterwards count as protocol errors.
- No combinational path from `rsp_*` to any output.

## Structure
- Shared package `adder_chk_pkg`: `chk_entry_t` struct {sum, cout, width, index}, state enum `chk_state_e`, counter width constant `CNT_W`=32.
- Sub-module `chk_fifo`: synchronous FIFO of `chk_entry_t`, DEPTH entries, registered full/empty/count, simultaneous push/pop supported.
- Expected-value computation and masking stay in `adder_checker`.

## Test plan
- Width 4: a=1111, b=0001, cin=0, DUT returns sum=0000 cout=1 one cycle later → `pass_cnt`=1, `fail_cnt`=0, `err_flag`=0.
- Width 8: three vectors, second response sum=0x10 where expected 0x11 → `pass_cnt`=2, `fail_cnt`=1, `err_index`=1, `err_exp_sum`=0x11, `err_got_sum`=0x10.
- Width 4, a=0x0F, b=0, `rsp_sum`=0xFF (garbage upper bits) → pass; upper bits ignored.
- Push DEPTH=8 vectors with no responses → `stim_ready`=0 with `pending`=8; one response → `stim_ready`=1 next cycle.
- `rsp_valid` with empty queue → `proto_err`=1, `stim_ready`=0, later responses not counted; `clear` → all outputs 0, `stim_ready`=1.
- Width 0 and width 65 with a=b=all-ones, cin=1 → expected sum all-ones, cout=1 at MAX_WIDTH.
